// File: rtl/countdown_pkg.sv
// countdown_pkg: shared FSM states, segment constants and BCD-to-segment encoder
package countdown_pkg;

    typedef enum logic [1:0] {IDLE, LEVEL, COUNT, DONE} state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_L     = 8'hC7;

    // active-low segments, DP (bit7) always off
    function automatic logic [7:0] seg_enc(input logic [3:0] d);
        case (d)
            4'd0:    seg_enc = 8'hC0;
            4'd1:    seg_enc = 8'hF9;
            4'd2:    seg_enc = 8'hA4;
            4'd3:    seg_enc = 8'hB0;
            4'd4:    seg_enc = 8'h99;
            4'd5:    seg_enc = 8'h92;
            4'd6:    seg_enc = 8'h82;
            4'd7:    seg_enc = 8'hF8;
            4'd8:    seg_enc = 8'h80;
            4'd9:    seg_enc = 8'h90;
            default: seg_enc = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/countdown_timer_gen_if.sv
// countdown_timer_gen_if: control/status and segment bus between game FSM and timer
interface countdown_timer_gen_if #(parameter int NUM_DIGITS = 2);

    logic                    start;
    logic                    abort;
    logic                    pause;
    logic [4*NUM_DIGITS-1:0] startCount;
    logic [3:0]              curLevel;
    logic                    busy;
    logic                    doneCounting;
    logic [8*NUM_DIGITS-1:0] seg;

    modport master (output start, abort, pause, startCount, curLevel,
                    input  busy, doneCounting, seg);
    modport slave  (input  start, abort, pause, startCount, curLevel,
                    output busy, doneCounting, seg);

endinterface

// File: rtl/cd_tick_prescaler.sv
// cd_tick_prescaler: divides Clk100M by TICK_DIV while enabled; clr restarts the period
module cd_tick_prescaler #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic Clk100M,
    input  logic resetN,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int W = $clog2(TICK_DIV);

    logic [W-1:0] cnt;

    assign tick = en && cnt == W'(TICK_DIV - 1);

    // frozen while en is low, so a paused tick cycle is simply postponed
    always_ff @(posedge Clk100M)
        if (!resetN || clr) cnt <= '0;
        else if (en)        cnt <= tick ? '0 : cnt + 1'b1;

endmodule

// File: rtl/countdown_timer_gen.sv
// countdown_timer_gen: shows "L<level>" then counts a BCD value down to zero on 7-seg digits
module countdown_timer_gen
    import countdown_pkg::*;
#(
    parameter int NUM_DIGITS    = 2,
    parameter int TICK_DIV      = 100_000_000,
    parameter int LEVEL_TICKS   = 1,
    parameter int SHOW_LEVEL    = 1,
    parameter int BLANK_LEADING = 1
) (
    input logic                Clk100M,
    input logic                resetN,
    countdown_timer_gen_if.slave bus
);

    localparam int CW = 4 * NUM_DIGITS;
    localparam int SW = 8 * NUM_DIGITS;
    localparam int LW = $clog2(LEVEL_TICKS + 1);

    state_t          state_q, state_n;
    logic [CW-1:0]   count_q, count_n, count_dec, count_ld;
    logic [SW-1:0]   seg_q, seg_n, seg_cnt, seg_lvl;
    logic [LW-1:0]   lvl_q, lvl_n;
    logic [NUM_DIGITS:0] borrow, zhi;
    logic            accept, kill, tick, cnt_zero;

    assign accept    = state_q == IDLE && bus.start && !bus.abort;
    assign kill      = state_q != IDLE && bus.abort;
    assign borrow[0] = 1'b1;
    assign cnt_zero  = borrow[NUM_DIGITS];
    assign zhi[NUM_DIGITS] = 1'b1;

    cd_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .Clk100M (Clk100M),
        .resetN  (resetN),
        .clr     (accept),
        .en      (state_q != IDLE && !bus.pause),
        .tick    (tick)
    );

    // per digit: borrow-chain decrement, load clamp, leading-zero detect, display bytes
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        logic [3:0] cd, nd, sd;
        assign cd = count_q[4*g +: 4];
        assign nd = count_n[4*g +: 4];
        assign sd = bus.startCount[4*g +: 4];
        assign count_dec[4*g +: 4] = borrow[g] ? (cd == 4'd0 ? 4'd9 : cd - 4'd1) : cd;
        assign borrow[g+1]         = borrow[g] && cd == 4'd0;
        assign count_ld[4*g +: 4]  = sd > 4'd9 ? 4'd9 : sd;
        assign seg_lvl[8*g +: 8]   = g == 0 ? seg_enc(bus.curLevel) : g == NUM_DIGITS - 1 ? SEG_L : SEG_BLANK;
        if (g == 0) begin : g_lsd
            assign zhi[0]        = zhi[1] && nd == 4'd0;
            assign seg_cnt[7:0] = seg_enc(nd);
        end else begin : g_hi
            assign zhi[g]              = zhi[g+1] && nd == 4'd0;
            assign seg_cnt[8*g +: 8]   = BLANK_LEADING != 0 && zhi[g] ? SEG_BLANK : seg_enc(nd);
        end
    end

    // display follows the state being entered; IDLE keeps whatever was last shown
    assign seg_n = kill ? {NUM_DIGITS{SEG_BLANK}} :
                   state_n == LEVEL ? seg_lvl :
                   state_n == IDLE  ? seg_q   : seg_cnt;

    // next state, count and level-tick counter; abort overrides every transition
    always_comb begin
        state_n = state_q;
        count_n = count_q;
        lvl_n   = lvl_q;
        if (kill) state_n = IDLE;
        else case (state_q)
            IDLE: if (accept) begin
                state_n = SHOW_LEVEL != 0 ? LEVEL : COUNT;
                count_n = count_ld;
                lvl_n   = '0;
            end
            LEVEL: if (tick) begin
                state_n = lvl_q == LW'(LEVEL_TICKS - 1) ? COUNT : LEVEL;
                lvl_n   = lvl_q + 1'b1;
            end
            COUNT: if (tick) begin
                count_n = cnt_zero ? count_q : count_dec;
                state_n = cnt_zero || count_dec == '0 ? DONE : COUNT;
            end
            default: state_n = IDLE;
        endcase
    end

    // registered state and outputs
    always_ff @(posedge Clk100M)
        if (!resetN) begin
            state_q <= IDLE;
            count_q <= '0;
            lvl_q   <= '0;
            seg_q   <= '1;
        end else begin
            state_q <= state_n;
            count_q <= count_n;
            lvl_q   <= lvl_n;
            seg_q   <= seg_n;
        end

    assign bus.busy         = state_q != IDLE;
    assign bus.doneCounting = state_q == DONE;
    assign bus.seg          = seg_q;

endmodule

// File: tb/tb_countdown_timer_gen.sv
// tb_countdown_timer_gen: three configurations checked every cycle against a tick-arithmetic model
module tb_countdown_timer_gen;

    localparam int DIV = 4;

    logic       Clk100M = 1'b0;
    logic       resetN, start, abort, pause;
    logic [7:0] sc;
    logic [3:0] lvl;

    int errors = 0, checks = 0, cyc = 0;

    int cfg_n  [3] = '{2, 2, 1};
    int cfg_sl [3] = '{1, 0, 1};
    int cfg_bl [3] = '{1, 0, 1};
    int cfg_lt [3] = '{1, 1, 2};

    bit          m_busy [3];
    bit          m_done [3];
    int          m_eff  [3];
    int          m_sv   [3];
    logic [15:0] m_seg  [3];

    logic [15:0] a_seg  [3];
    logic        a_busy [3];
    logic        a_done [3];

    always #5 Clk100M = ~Clk100M;

    countdown_timer_gen_if #(.NUM_DIGITS(2)) bi0 ();
    countdown_timer_gen_if #(.NUM_DIGITS(2)) bi1 ();
    countdown_timer_gen_if #(.NUM_DIGITS(1)) bi2 ();

    assign bi0.start = start;  assign bi0.abort = abort;  assign bi0.pause = pause;
    assign bi1.start = start;  assign bi1.abort = abort;  assign bi1.pause = pause;
    assign bi2.start = start;  assign bi2.abort = abort;  assign bi2.pause = pause;
    assign bi0.startCount = sc;       assign bi0.curLevel = lvl;
    assign bi1.startCount = sc;       assign bi1.curLevel = lvl;
    assign bi2.startCount = sc[3:0];  assign bi2.curLevel = lvl;

    assign a_seg[0] = bi0.seg;  assign a_busy[0] = bi0.busy;  assign a_done[0] = bi0.doneCounting;
    assign a_seg[1] = bi1.seg;  assign a_busy[1] = bi1.busy;  assign a_done[1] = bi1.doneCounting;
    assign a_seg[2] = {8'h00, bi2.seg};  assign a_busy[2] = bi2.busy;  assign a_done[2] = bi2.doneCounting;

    countdown_timer_gen #(.NUM_DIGITS(2), .TICK_DIV(DIV), .LEVEL_TICKS(1), .SHOW_LEVEL(1), .BLANK_LEADING(1))
        dut0 (.Clk100M(Clk100M), .resetN(resetN), .bus(bi0));
    countdown_timer_gen #(.NUM_DIGITS(2), .TICK_DIV(DIV), .LEVEL_TICKS(1), .SHOW_LEVEL(0), .BLANK_LEADING(0))
        dut1 (.Clk100M(Clk100M), .resetN(resetN), .bus(bi1));
    countdown_timer_gen #(.NUM_DIGITS(1), .TICK_DIV(DIV), .LEVEL_TICKS(2), .SHOW_LEVEL(1), .BLANK_LEADING(1))
        dut2 (.Clk100M(Clk100M), .resetN(resetN), .bus(bi2));

    function automatic logic [7:0] enc(input int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;  default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [15:0] blank_of(input int i);
        return cfg_n[i] == 2 ? 16'hFFFF : 16'h00FF;
    endfunction

    function automatic logic [15:0] count_seg(input int i, input int v);
        logic [15:0] r;
        int p;
        r = '0;
        p = 1;
        for (int j = 0; j < cfg_n[i]; j++) begin
            r[8*j +: 8] = (cfg_bl[i] != 0 && j > 0 && v < p) ? 8'hFF : enc((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic int clampval(input int i);
        int s, p;
        logic [3:0] d;
        s = 0;
        p = 1;
        for (int j = 0; j < cfg_n[i]; j++) begin
            d = sc[4*j +: 4];
            s = s + (d > 4'd9 ? 9 : int'(d)) * p;
            p = p * 10;
        end
        return s;
    endfunction

    // expected display after m_eff unpaused busy cycles since the accept edge
    task automatic show(input int i);
        int k, c, v;
        k = m_eff[i] / DIV;
        if (cfg_sl[i] != 0 && k < cfg_lt[i])
            m_seg[i] = cfg_n[i] == 2 ? {8'hC7, enc(int'(lvl))} : {8'h00, enc(int'(lvl))};
        else begin
            c = k - (cfg_sl[i] != 0 ? cfg_lt[i] : 0);
            v = m_sv[i] - c;
            if (v < 0) v = 0;
            if (c >= (m_sv[i] > 0 ? m_sv[i] : 1)) begin
                m_done[i] = 1'b1;
                v = 0;
            end
            m_seg[i] = count_seg(i, v);
        end
    endtask

    task automatic model_edge(input int i);
        if (!resetN) begin
            m_busy[i] = 1'b0;
            m_done[i] = 1'b0;
            m_seg[i]  = blank_of(i);
        end else if (m_done[i]) begin
            m_done[i] = 1'b0;
            m_busy[i] = 1'b0;
            if (abort) m_seg[i] = blank_of(i);
        end else if (!m_busy[i]) begin
            if (start && !abort) begin
                m_busy[i] = 1'b1;
                m_eff[i]  = 0;
                m_sv[i]   = clampval(i);
                show(i);
            end
        end else if (abort) begin
            m_busy[i] = 1'b0;
            m_seg[i]  = blank_of(i);
        end else begin
            if (!pause) m_eff[i]++;
            show(i);
        end
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge Clk100M);
        for (int i = 0; i < 3; i++) model_edge(i);
        cyc++;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("busy%0d", i), {15'd0, a_busy[i]}, {15'd0, m_busy[i]});
            chk($sformatf("done%0d", i), {15'd0, a_done[i]}, {15'd0, m_done[i]});
            chk($sformatf("seg%0d", i),  a_seg[i], m_seg[i]);
        end
    endtask

    task automatic wait_done(input int i, input int maxc, output int dt);
        dt = -1;
        for (int k = 0; k < maxc; k++) begin
            step();
            if (a_done[i] && dt < 0) dt = cyc;
            if (!a_busy[i]) break;
        end
    endtask

    task automatic go(input logic [7:0] v, output int t0);
        sc = v;
        start = 1'b1;
        step();
        t0 = cyc;
        start = 1'b0;
    endtask

    initial begin
        int t0, dt, nd;
        resetN = 1'b0; start = 1'b0; abort = 1'b0; pause = 1'b0; sc = 8'h00; lvl = 4'd3;
        step();
        step();
        resetN = 1'b1;
        chk("reset_seg", a_seg[0], 16'hFFFF);
        chk("reset_busy", {15'd0, a_busy[0]}, 16'd0);

        go(8'h12, t0);
        repeat (10) step();
        resetN = 1'b0;
        step();
        resetN = 1'b1;
        chk("midrun_reset_seg", a_seg[0], 16'hFFFF);
        chk("midrun_reset_busy", {15'd0, a_busy[0]}, 16'd0);
        chk("midrun_reset_done", {15'd0, a_done[0]}, 16'd0);
        step();

        go(8'h12, t0);
        chk("level_seg", a_seg[0], 16'hC7B0);
        chk("n1_level_seg", a_seg[2], 16'h00B0);
        chk("nolevel_seg", a_seg[1], 16'hF9A4);
        repeat (4) step();
        chk("count12_seg", a_seg[0], 16'hF9A4);
        wait_done(0, 100, dt);
        chk("done_latency", 16'(dt - t0), 16'd52);
        chk("final_zero_seg", a_seg[0], 16'hFFC0);

        go(8'h12, t0);
        repeat (25) step();
        pause = 1'b1;
        repeat (10) step();
        chk("paused_seg", a_seg[0], 16'hFFF8);
        pause = 1'b0;
        wait_done(0, 100, dt);
        chk("paused_latency", 16'(dt - t0), 16'd62);

        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", {15'd0, a_busy[0]}, 16'd0);
        go(8'h12, t0);
        repeat (32) step();
        chk("count05_seg", a_seg[0], 16'hFF92);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", {15'd0, a_busy[0]}, 16'd0);
        chk("abort_seg", a_seg[0], 16'hFFFF);
        nd = 0;
        repeat (60) begin
            step();
            if (a_done[0]) nd++;
        end
        chk("abort_no_done", 16'(nd), 16'd0);

        go(8'h0A, t0);
        repeat (4) step();
        chk("clamp09_seg", a_seg[0], 16'hFF90);
        abort = 1'b1;
        step();
        abort = 1'b0;
        go(8'h00, t0);
        wait_done(1, 20, dt);
        chk("zero_nolevel_latency", 16'(dt - t0), 16'd4);
        wait_done(0, 20, dt);
        chk("zero_level_latency", 16'(dt - t0), 16'd8);

        lvl = 4'd3;
        go(8'h12, t0);
        repeat (2) step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(0, 100, dt);
        chk("busy_start_latency", 16'(dt - t0), 16'd52);

        for (int n = 0; n < 4000; n++) begin
            resetN = ($urandom % 400) != 0;
            start  = ($urandom % 8) == 0;
            abort  = ($urandom % 64) == 0;
            pause  = ($urandom % 6) == 0;
            sc     = ($urandom % 4) == 0 ? 8'($urandom) : {4'h0, 4'($urandom)};
            lvl    = 4'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
